// File: rtl/ifu_pipe_ctrl.sv
// ifu_pipe_ctrl
//   Flow controller between the fetch response path and the IF/ID register.
//   Buffers responses while decode is stalled (skid FIFO), discards stale
//   in-flight responses after a redirect (DRAIN state), and holds off fetch
//   request issue so the skid FIFO cannot overflow.
//
// Optional feature macro: IFU_PIPE_CTRL_PERF_EN
//   defined   : perf_stall_cnt_o / perf_drop_cnt_o are 32-bit saturating counters
//   undefined : both perf outputs tied to 0, no counter flops
//
// Ports
//   clk, rst               : clock, synchronous active-high reset
//   fetch_req_fire_i       : fetch request accepted by imem this cycle
//   resp_*_i               : in-order fetch response and its payload
//   flush_i                : redirect from EXU (highest priority)
//   id_stall_i             : hazard stall from decode
//   fetch_hold_o           : IFU must not issue a request this cycle
//   pipe_stall_o/flush_o   : IF/ID register stall / flush controls
//   inst_valid_o, payload  : instruction presented to IF/ID (zeros when invalid)
//   ovf_err_o              : sticky skid-FIFO overflow flag
//   perf_*_cnt_o           : performance counters
module ifu_pipe_ctrl #(
    parameter int FIFO_DEPTH      = 2,
    parameter int OST_MAX         = 3,
    parameter int INST_DATA_WIDTH = 32,
    parameter int INST_ADDR_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fetch_req_fire_i,
    input  logic                       resp_valid_i,
    input  logic [INST_DATA_WIDTH-1:0] resp_inst_i,
    input  logic [INST_ADDR_WIDTH-1:0] resp_addr_i,
    input  logic                       resp_pred_branch_i,
    input  logic                       resp_pred_jalr_i,
    input  logic [INST_ADDR_WIDTH-1:0] resp_branch_addr_i,
    input  logic                       flush_i,
    input  logic                       id_stall_i,
    output logic                       fetch_hold_o,
    output logic                       pipe_stall_o,
    output logic                       pipe_flush_o,
    output logic                       inst_valid_o,
    output logic [INST_DATA_WIDTH-1:0] inst_o,
    output logic [INST_ADDR_WIDTH-1:0] inst_addr_o,
    output logic                       pred_branch_o,
    output logic                       pred_jalr_o,
    output logic [INST_ADDR_WIDTH-1:0] branch_addr_o,
    output logic                       ovf_err_o,
    output logic [31:0]                perf_stall_cnt_o,
    output logic [31:0]                perf_drop_cnt_o
);

    localparam int OST_W = $clog2(OST_MAX + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int SUM_W = ((OST_W > PTR_W + 1) ? OST_W : PTR_W + 1) + 1;
    localparam logic [OST_W:0] OST_LIM = (OST_W + 1)'(OST_MAX);

    typedef struct packed {
        logic [INST_DATA_WIDTH-1:0] inst;
        logic [INST_ADDR_WIDTH-1:0] addr;
        logic                       pred_branch;
        logic                       pred_jalr;
        logic [INST_ADDR_WIDTH-1:0] branch_addr;
    } fetch_ent_t;

    typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

    state_t                         state;
    logic [OST_W-1:0]               ost_cnt;
    logic [OST_W-1:0]               drop_cnt;
    fetch_ent_t [FIFO_DEPTH-1:0]    fifo_mem;
    logic [PTR_W:0]                 wptr, rptr;
    logic [PTR_W:0]                 fifo_cnt;
    logic                           fifo_empty, fifo_full;

    fetch_ent_t                     resp_ent, out_ent;
    logic                           in_drain;
    logic                           resp_keep, bypass, pop, push, do_write, ovf_hit;
    logic [OST_W:0]                 ost_inc, ost_dec;
    logic [OST_W-1:0]               ost_next;
    logic [SUM_W-1:0]               fill;

    assign resp_ent = '{inst:        resp_inst_i,
                        addr:        resp_addr_i,
                        pred_branch: resp_pred_branch_i,
                        pred_jalr:   resp_pred_jalr_i,
                        branch_addr: resp_branch_addr_i};

    // Extra pointer bit distinguishes full from empty.
    assign fifo_cnt   = wptr - rptr;
    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[PTR_W] != rptr[PTR_W]) &&
                        (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]);

    assign in_drain  = (state == DRAIN);
    assign resp_keep = resp_valid_i & ~flush_i & ~in_drain;
    assign pop       = ~flush_i & ~id_stall_i & ~fifo_empty;
    // Bypass only when nothing older is buffered, so ordering is preserved.
    assign bypass    = resp_keep & ~id_stall_i & fifo_empty;
    assign push      = resp_keep & ~bypass;
    assign ovf_hit   = push & fifo_full & ~pop;
    assign do_write  = push & (~fifo_full | pop);

    // Outstanding count; a response with nothing outstanding (pre-reset
    // request) must not underflow, and the count is clipped at OST_MAX.
    assign ost_inc  = {1'b0, ost_cnt} + (OST_W + 1)'(fetch_req_fire_i);
    assign ost_dec  = (resp_valid_i && ost_inc != '0) ? ost_inc - (OST_W + 1)'(1) : ost_inc;
    assign ost_next = (ost_dec > OST_LIM) ? OST_LIM[OST_W-1:0] : ost_dec[OST_W-1:0];

    assign fill         = SUM_W'(ost_cnt) + SUM_W'(fifo_cnt);
    assign fetch_hold_o = (fill >= SUM_W'(FIFO_DEPTH)) | (ost_cnt == OST_LIM[OST_W-1:0]);

    assign pipe_stall_o = id_stall_i & ~flush_i;
    assign pipe_flush_o = flush_i;

    assign out_ent       = pop ? fifo_mem[rptr[PTR_W-1:0]] : (bypass ? resp_ent : '0);
    assign inst_valid_o  = pop | bypass;
    assign inst_o        = out_ent.inst;
    assign inst_addr_o   = out_ent.addr;
    assign pred_branch_o = out_ent.pred_branch;
    assign pred_jalr_o   = out_ent.pred_jalr;
    assign branch_addr_o = out_ent.branch_addr;

    // Control state: RUN/DRAIN, outstanding and drop counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            ost_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            ost_cnt <= ost_next;
            if (flush_i) begin
                // Everything still in flight, including a request firing now, is stale.
                drop_cnt <= ost_next;
                state    <= (ost_next != '0) ? DRAIN : RUN;
            end else if (in_drain && resp_valid_i) begin
                drop_cnt <= drop_cnt - OST_W'(1);
                if (drop_cnt == OST_W'(1))
                    state <= RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            ovf_err_o <= 1'b0;
        end else if (flush_i) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_write) wptr <= wptr + (PTR_W + 1)'(1);
            if (pop)      rptr <= rptr + (PTR_W + 1)'(1);
            if (ovf_hit)  ovf_err_o <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write && !flush_i)
            fifo_mem[wptr[PTR_W-1:0]] <= resp_ent;
    end

`ifdef IFU_PIPE_CTRL_PERF_EN
    logic        resp_drop;
    logic [31:0] stall_cnt, drop_cnt_perf;

    assign resp_drop = resp_valid_i & (flush_i | in_drain);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt     <= '0;
            drop_cnt_perf <= '0;
        end else begin
            if (pipe_stall_o && stall_cnt != '1)
                stall_cnt <= stall_cnt + 32'd1;
            if (resp_drop && drop_cnt_perf != '1)
                drop_cnt_perf <= drop_cnt_perf + 32'd1;
        end
    end

    assign perf_stall_cnt_o = stall_cnt;
    assign perf_drop_cnt_o  = drop_cnt_perf;
`else
    assign perf_stall_cnt_o = '0;
    assign perf_drop_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_ifu_pipe_ctrl.sv
// Directed bench for ifu_pipe_ctrl with a payload scoreboard: each response
// expected to reach IF/ID is queued when driven and checked when presented.
module tb_ifu_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req_fire_i, resp_valid_i, flush_i, id_stall_i;
    logic [31:0] resp_inst_i, resp_addr_i, resp_branch_addr_i;
    logic        resp_pred_branch_i, resp_pred_jalr_i;
    logic        fetch_hold_o, pipe_stall_o, pipe_flush_o, inst_valid_o;
    logic [31:0] inst_o, inst_addr_o, branch_addr_o;
    logic        pred_branch_o, pred_jalr_o, ovf_err_o;
    logic [31:0] perf_stall_cnt_o, perf_drop_cnt_o;

    int n_chk  = 0;
    int n_fail = 0;
    logic [97:0] sb[$];

    always #5 clk = ~clk;

    ifu_pipe_ctrl #(.FIFO_DEPTH(2), .OST_MAX(3), .INST_DATA_WIDTH(32), .INST_ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .fetch_req_fire_i(fetch_req_fire_i), .resp_valid_i(resp_valid_i),
        .resp_inst_i(resp_inst_i), .resp_addr_i(resp_addr_i),
        .resp_pred_branch_i(resp_pred_branch_i), .resp_pred_jalr_i(resp_pred_jalr_i),
        .resp_branch_addr_i(resp_branch_addr_i),
        .flush_i(flush_i), .id_stall_i(id_stall_i),
        .fetch_hold_o(fetch_hold_o), .pipe_stall_o(pipe_stall_o), .pipe_flush_o(pipe_flush_o),
        .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
        .pred_branch_o(pred_branch_o), .pred_jalr_o(pred_jalr_o), .branch_addr_o(branch_addr_o),
        .ovf_err_o(ovf_err_o), .perf_stall_cnt_o(perf_stall_cnt_o), .perf_drop_cnt_o(perf_drop_cnt_o)
    );

    // Payload for a given address: {inst, addr, pred_branch, pred_jalr, branch_addr}
    function automatic logic [97:0] pay(input logic [31:0] a);
        return {a ^ 32'h1357_9bdf, a, a[2], a[3], a + 32'h40};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic exp_push(input logic [31:0] a);
        sb.push_back(pay(a));
    endtask

    // One cycle: drive at posedge+1, check at negedge, return at next posedge+1.
    task automatic step(input string tag, input logic fire, input logic rv, input logic [31:0] a,
                        input logic fl, input logic st, input logic exp_valid, input logic exp_hold);
        logic [97:0] e;
        fetch_req_fire_i   = fire;
        resp_valid_i       = rv;
        resp_inst_i        = a ^ 32'h1357_9bdf;
        resp_addr_i        = a;
        resp_pred_branch_i = a[2];
        resp_pred_jalr_i   = a[3];
        resp_branch_addr_i = a + 32'h40;
        flush_i            = fl;
        id_stall_i         = st;
        @(negedge clk);
        chk({tag, " valid"}, 128'(inst_valid_o), 128'(exp_valid));
        chk({tag, " hold"}, 128'(fetch_hold_o), 128'(exp_hold));
        chk({tag, " pstall"}, 128'(pipe_stall_o), 128'(st & ~fl));
        chk({tag, " pflush"}, 128'(pipe_flush_o), 128'(fl));
        if (inst_valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                chk({tag, " unexpected_inst"}, 128'(inst_addr_o), 128'hdead);
            end else begin
                e = sb.pop_front();
                chk({tag, " payload"},
                    128'({inst_o, inst_addr_o, pred_branch_o, pred_jalr_o, branch_addr_o}), 128'(e));
            end
        end else begin
            chk({tag, " zero_payload"},
                128'({inst_o, inst_addr_o, pred_branch_o, pred_jalr_o, branch_addr_o}), 128'(0));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        fetch_req_fire_i = 0; resp_valid_i = 0; flush_i = 0; id_stall_i = 0;
        resp_inst_i = 0; resp_addr_i = 0; resp_branch_addr_i = 0;
        resp_pred_branch_i = 0; resp_pred_jalr_i = 0;
    endtask

    initial begin
        rst = 1'b1;
        idle_in();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst outputs",
            128'({fetch_hold_o, pipe_stall_o, pipe_flush_o, inst_valid_o, inst_o, inst_addr_o,
                  pred_branch_o, pred_jalr_o, branch_addr_o, ovf_err_o}), 128'(0));
        chk("rst perf", 128'({perf_stall_cnt_o, perf_drop_cnt_o}), 128'(0));
        chk("rst drop_cnt", 128'(dut.drop_cnt), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Stream: back-to-back responses bypass in the same cycle.
        step("s0", 1, 0, 32'h0,  0, 0, 0, 0);
        exp_push(32'h10); step("s1", 1, 1, 32'h10, 0, 0, 1, 0);
        exp_push(32'h14); step("s2", 1, 1, 32'h14, 0, 0, 1, 0);
        exp_push(32'h18); step("s3", 1, 1, 32'h18, 0, 0, 1, 0);
        exp_push(32'h1c); step("s4", 0, 1, 32'h1c, 0, 0, 1, 0);
        chk("stream fifo_empty", 128'(dut.fifo_cnt), 128'(0));

        // Stall: two responses buffered, released in order.
        step("t0", 1, 0, 32'h0,   0, 1, 0, 0);
        exp_push(32'h100); step("t1", 1, 1, 32'h100, 0, 1, 0, 0);
        exp_push(32'h104); step("t2", 0, 1, 32'h104, 0, 1, 0, 1);
        step("t3", 0, 0, 32'h0, 0, 0, 1, 1);
        step("t4", 0, 0, 32'h0, 0, 0, 1, 0);
        step("t5", 0, 0, 32'h0, 0, 0, 0, 0);

        // Flush drain with three outstanding requests.
        step("f0", 1, 0, 32'h0, 0, 0, 0, 0);
        step("f1", 1, 0, 32'h0, 0, 0, 0, 0);
        step("f2", 1, 0, 32'h0, 0, 0, 0, 1);
        step("f3", 0, 0, 32'h0, 1, 0, 0, 1);
        chk("f3 drop_cnt", 128'(dut.drop_cnt), 128'(3));
        chk("f3 drain", 128'(dut.in_drain), 128'(1));
        step("f4", 0, 1, 32'ha0, 0, 0, 0, 1);
        chk("f4 drop_cnt", 128'(dut.drop_cnt), 128'(2));
        step("f5", 0, 1, 32'ha4, 0, 0, 0, 1);
        chk("f5 drain", 128'(dut.in_drain), 128'(1));
        step("f6", 1, 1, 32'ha8, 0, 0, 0, 0);
        chk("f6 drain", 128'(dut.in_drain), 128'(0));
        exp_push(32'h200); step("f7", 0, 1, 32'h200, 0, 0, 1, 0);

        // Flush with same-cycle response, request fire and stall.
        step("e0", 1, 0, 32'h0,   0, 0, 0, 0);
        step("e1", 1, 1, 32'h300, 1, 1, 0, 0);
        chk("e1 drop_cnt", 128'(dut.drop_cnt), 128'(1));
        step("e2", 0, 1, 32'h304, 0, 0, 0, 0);
        chk("e2 drop_cnt", 128'(dut.drop_cnt), 128'(0));
        step("e3", 0, 0, 32'h0, 0, 0, 0, 0);

        // Overflow: third response pushed into a full FIFO is dropped.
        step("o0", 1, 0, 32'h0, 0, 1, 0, 0);
        exp_push(32'h400); step("o1", 1, 1, 32'h400, 0, 1, 0, 0);
        exp_push(32'h404); step("o2", 1, 1, 32'h404, 0, 1, 0, 1);
        step("o3", 0, 1, 32'h408, 0, 1, 0, 1);
        chk("o3 ovf", 128'(ovf_err_o), 128'(1));
        step("o4", 0, 0, 32'h0, 0, 0, 1, 1);
        step("o5", 0, 0, 32'h0, 0, 0, 1, 0);
        step("o6", 0, 0, 32'h0, 0, 0, 0, 0);
        chk("o6 ovf sticky", 128'(ovf_err_o), 128'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("ovf after rst", 128'(ovf_err_o), 128'(0));

        // Perf: 5 stall cycles and 2 dropped responses.
        for (int i = 0; i < 5; i++) step("p_st", 0, 0, 32'h0, 0, 1, 0, 0);
        step("p0", 1, 0, 32'h0, 0, 0, 0, 0);
        step("p1", 1, 0, 32'h0, 0, 0, 0, 0);
        step("p2", 0, 0, 32'h0, 1, 0, 0, 1);
        step("p3", 0, 1, 32'h500, 0, 0, 0, 1);
        step("p4", 0, 1, 32'h504, 0, 0, 0, 0);
        step("p5", 0, 0, 32'h0, 0, 0, 0, 0);
`ifdef IFU_PIPE_CTRL_PERF_EN
        chk("perf stall", 128'(perf_stall_cnt_o), 128'(5));
        chk("perf drop", 128'(perf_drop_cnt_o), 128'(2));
`else
        chk("perf stall tied", 128'(perf_stall_cnt_o), 128'(0));
        chk("perf drop tied", 128'(perf_drop_cnt_o), 128'(0));
`endif
        chk("sb drained", 128'(sb.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
